elpis_host_mailbox: RTL and testbench
=====================================

# elpis_host_mailbox

Word-level I/O mailbox between the Elpis core and the management SoC's logic-analyzer (LA) port. Elpis output words are buffered in a small FIFO and popped by host toggle-acknowledges. Elpis input requests stall the core until the host delivers a word by toggle handshake. It sits on the Elpis side of the chip controller: core-facing ports connect to Elpis, host-facing ports map onto LA bits.

## Interface
Parameters:
- DATA_W, 32, word width of both directions
- OUT_DEPTH, 4, output FIFO depth; power of two, ≥2

Ports:
- clk  in  1  block clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- core_out_valid  in  1  Elpis presents an output word this cycle
- core_out_data  in  DATA_W  output word
- core_out_ready  out  1  FIFO can accept; push = valid & ready
- core_in_req  in  1  Elpis requests an input word; level, held until core_in_valid
- core_in_data  out  DATA_W  delivered input word, registered
- core_in_valid  out  1  one-cycle pulse; core_in_data valid
- core_stall  out  1  Elpis must hold pipeline
- host_out_data  out  DATA_W  FIFO head word
- host_out_pending  out  1  FIFO non-empty
- host_out_ack  in  1  toggle; each change pops one word
- host_in_req  out  1  core is waiting for an input word
- host_in_data  in  DATA_W  input word from host; stable across toggle
- host_in_toggle  in  1  toggle; each change delivers host_in_data
- protocol_err  out  1  sticky: ack while empty, or in-toggle while not waiting

## Operation
- Host toggles pass through a 2-flop synchronizer plus a history flop. An edge is sync2 != hist. Sync and history flops reset to 0, so the host must hold both toggles at 0 until rst deasserts.
- Output FIFO:
  - Circular buffer with rd_ptr/wr_ptr (log2 OUT_DEPTH bits, wrap mod OUT_DEPTH) and count (log2 OUT_DEPTH + 1 bits).
  - core_out_ready = (count != OUT_DEPTH). It depends only on count, so it is not relieved by a same-cycle pop.
  - Push: write mem[wr_ptr], wr_ptr++, count++.
  - Pop on ack edge when count != 0: rd_ptr++, count--.
  - Ack edge while empty: no pop, protocol_err set.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - host_out_data = mem[rd_ptr]. host_out_pending = (count != 0).
- Input FSM, states IDLE, WAIT, DELIVER:
  - IDLE: core_in_req=1 → WAIT. An in-toggle edge in IDLE or DELIVER is discarded and sets protocol_err.
  - WAIT: host_in_req=1. On an in-toggle edge, capture host_in_data into core_in_data → DELIVER.
  - DELIVER: core_in_valid=1 for exactly one cycle → IDLE. The core drops core_in_req in the DELIVER cycle. If core_in_req is still 1 in IDLE, it is a new request.
- core_stall = (core_out_valid & ~core_out_ready) | (core_in_req & state != DELIVER).
- protocol_err clears only on rst.

## Timing
- Reset values: core_out_ready=1, core_in_data=0, core_in_valid=0, core_stall follows inputs (0 with inputs low), host_out_data=mem[0] (don't-care), host_out_pending=0, host_in_req=0, protocol_err=0. FIFO empty, FSM IDLE, all pointers 0.
- Reset mid-operation: FIFO contents discarded, FSM to IDLE, pending input lost.
- Push at edge E → host_out_pending=1 and host_out_data valid after E.
- Toggle change sampled at edge E0 → edge detected after E1 → action at E2. Pop, capture, and the core_in_valid rise all occur at E2; core_in_valid falls at E3.
- Host holds host_in_data stable from its toggle change through E2, i.e. ≥3 cycles.
- Host issues a new ack toggle only after observing the updated host_out_data. Minimum toggle spacing is 2 cycles; closer toggles may merge.
- Throughput: one push per cycle; one pop per 2 cycles (host-bound).

## Test plan
- Reset, push 0x11111111..0x44444444 on 4 consecutive cycles (OUT_DEPTH=4) → core_out_ready=0 after the 4th, host_out_data=0x11111111. A 5th valid asserts core_stall and is not stored.
- Full FIFO: push held during an ack toggle → pop at E2, ready=1 after E2, held word accepted next cycle. Drain order is 0x22222222, 0x33333333, 0x44444444, 5th word.
- Empty FIFO, single push coincident with a pop edge on a 1-entry FIFO → count stays 1, pointers both advance, data ordering correct.
- core_in_req=1, host sets host_in_data=0xDEADBEEF, toggles → host_in_req=1 until E2. core_in_valid pulses one cycle with core_in_data=0xDEADBEEF; core_stall=1 until the DELIVER cycle.
- Ack toggle with FIFO empty, and in-toggle in IDLE → no state change, protocol_err=1 and sticky until rst.
- Assert rst asynchronously while in WAIT with 2 words queued → outputs immediately at reset values; after release, a new request completes normally.

Source files
------------

// File: rtl/elpis_host_mailbox.sv
// Word-level mailbox between the Elpis core and the host logic-analyzer port.
// Core output words queue in a small FIFO popped by host ack toggles; core input
// requests stall the core until the host delivers a word with a toggle handshake.
module elpis_host_mailbox #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  // Core-facing output path
  input  logic              core_out_valid,
  input  logic [DATA_W-1:0] core_out_data,
  output logic              core_out_ready,
  // Core-facing input path
  input  logic              core_in_req,
  output logic [DATA_W-1:0] core_in_data,
  output logic              core_in_valid,
  output logic              core_stall,
  // Host-facing output path
  output logic [DATA_W-1:0] host_out_data,
  output logic              host_out_pending,
  input  logic              host_out_ack,
  // Host-facing input path
  output logic              host_in_req,
  input  logic [DATA_W-1:0] host_in_data,
  input  logic              host_in_toggle,
  output logic              protocol_err
);

  localparam int unsigned PtrW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(OUT_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDeliver
  } in_state_e;

  // Toggle synchronizers and history flops
  logic ack_s1_q, ack_s2_q, ack_hist_q;
  logic tog_s1_q, tog_s2_q, tog_hist_q;
  logic ack_edge, tog_edge;

  // FIFO state
  logic [DATA_W-1:0] mem_q [OUT_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              push, pop;

  // Input FSM state
  in_state_e         state_q, state_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic              err_q, err_d;

  // Host toggles cross into the block clock; an edge is sync2 differing from history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_s1_q   <= 1'b0;
      ack_s2_q   <= 1'b0;
      ack_hist_q <= 1'b0;
      tog_s1_q   <= 1'b0;
      tog_s2_q   <= 1'b0;
      tog_hist_q <= 1'b0;
    end else begin
      ack_s1_q   <= host_out_ack;
      ack_s2_q   <= ack_s1_q;
      ack_hist_q <= ack_s2_q;
      tog_s1_q   <= host_in_toggle;
      tog_s2_q   <= tog_s1_q;
      tog_hist_q <= tog_s2_q;
    end
  end

  assign ack_edge = ack_s2_q ^ ack_hist_q;
  assign tog_edge = tog_s2_q ^ tog_hist_q;

  // Ready depends only on count, so a same-cycle pop does not free a slot early
  assign core_out_ready   = (count_q != CntFull);
  assign host_out_pending = (count_q != '0);
  assign host_out_data    = mem_q[rd_ptr_q];
  assign push             = core_out_valid & core_out_ready;
  assign pop              = ack_edge & host_out_pending;

  // Storage array carries no reset; contents are meaningless while count is zero
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= core_out_data;
    end
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Input FSM next-state, capture and sticky protocol error
  always_comb begin
    state_d   = state_q;
    in_data_d = in_data_q;
    err_d     = err_q;
    if (ack_edge && !host_out_pending) begin
      err_d = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (tog_edge) begin
          err_d = 1'b1;
        end
        if (core_in_req) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (tog_edge) begin
          in_data_d = host_in_data;
          state_d   = StDeliver;
        end
      end
      StDeliver: begin
        if (tog_edge) begin
          err_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers for FIFO control and input FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= StIdle;
      in_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      in_data_q <= in_data_d;
      err_q     <= err_d;
    end
  end

  assign core_in_data  = in_data_q;
  assign core_in_valid = (state_q == StDeliver);
  assign host_in_req   = (state_q == StWait);
  assign protocol_err  = err_q;
  assign core_stall    = (core_out_valid & ~core_out_ready) |
                         (core_in_req & (state_q != StDeliver));

endmodule

// File: tb/tb_elpis_host_mailbox.sv
// Directed self-checking bench for elpis_host_mailbox (DATA_W=32, OUT_DEPTH=4).
module tb_elpis_host_mailbox;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_out_valid;
  logic [31:0] core_out_data;
  logic        core_out_ready;
  logic        core_in_req;
  logic [31:0] core_in_data;
  logic        core_in_valid;
  logic        core_stall;
  logic [31:0] host_out_data;
  logic        host_out_pending;
  logic        host_out_ack;
  logic        host_in_req;
  logic [31:0] host_in_data;
  logic        host_in_toggle;
  logic        protocol_err;

  int vectors = 0;
  int errors  = 0;

  elpis_host_mailbox #(
    .DATA_W   (32),
    .OUT_DEPTH(4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .core_out_valid  (core_out_valid),
    .core_out_data   (core_out_data),
    .core_out_ready  (core_out_ready),
    .core_in_req     (core_in_req),
    .core_in_data    (core_in_data),
    .core_in_valid   (core_in_valid),
    .core_stall      (core_stall),
    .host_out_data   (host_out_data),
    .host_out_pending(host_out_pending),
    .host_out_ack    (host_out_ack),
    .host_in_req     (host_in_req),
    .host_in_data    (host_in_data),
    .host_in_toggle  (host_in_toggle),
    .protocol_err    (protocol_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    host_out_ack   = 1'b0;
    host_in_toggle = 1'b0;
    core_out_valid = 1'b0;
    core_in_req    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    core_out_valid = 1'b0;
    core_out_data  = '0;
    core_in_req    = 1'b0;
    host_out_ack   = 1'b0;
    host_in_data   = '0;
    host_in_toggle = 1'b0;
    tick();
    tick();
    vectors++; if (core_out_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", core_out_ready); end
    vectors++; if (host_out_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", host_out_pending); end
    vectors++; if (host_in_req !== 1'b0) begin errors++; $display("FAIL reset_host_in_req got %b want 0", host_in_req); end
    vectors++; if (core_in_valid !== 1'b0) begin errors++; $display("FAIL reset_in_valid got %b want 0", core_in_valid); end
    vectors++; if (core_in_data !== 32'h0) begin errors++; $display("FAIL reset_in_data got %h want 0", core_in_data); end
    vectors++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", protocol_err); end
    vectors++; if (core_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", core_stall); end
    rst = 1'b0;
    tick();
  endtask

  // Four back-to-back pushes fill the FIFO; a fifth valid stalls
  task automatic test_fill();
    logic [31:0] words [4];
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) begin
      core_out_valid = 1'b1;
      core_out_data  = words[i];
      tick();
    end
    core_out_data = 32'h55555555;
    #1;
    vectors++; if (core_out_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b want 0", core_out_ready); end
    vectors++; if (host_out_data !== 32'h11111111) begin errors++; $display("FAIL fill_head got %h want 11111111", host_out_data); end
    vectors++; if (host_out_pending !== 1'b1) begin errors++; $display("FAIL fill_pending got %b want 1", host_out_pending); end
    vectors++; if (core_stall !== 1'b1) begin errors++; $display("FAIL fill_stall got %b want 1", core_stall); end
  endtask

  // Pop on a full FIFO with a held push, then drain in order
  task automatic test_full_pop();
    logic [31:0] expect_w [4];
    expect_w[0] = 32'h22222222; expect_w[1] = 32'h33333333;
    expect_w[2] = 32'h44444444; expect_w[3] = 32'h55555555;
    host_out_ack = ~host_out_ack;
    tick(); // E0
    tick(); // E1
    vectors++; if (core_out_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready_e1 got %b want 0", core_out_ready); end
    vectors++; if (host_out_data !== 32'h11111111) begin errors++; $display("FAIL full_pop_head_e1 got %h want 11111111", host_out_data); end
    tick(); // E2: pop
    vectors++; if (core_out_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready_e2 got %b want 1", core_out_ready); end
    vectors++; if (core_stall !== 1'b0) begin errors++; $display("FAIL full_pop_stall_e2 got %b want 0", core_stall); end
    tick(); // held word accepted
    core_out_valid = 1'b0;
    #1;
    vectors++; if (core_out_ready !== 1'b0) begin errors++; $display("FAIL full_pop_refill got %b want 0", core_out_ready); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (host_out_data !== expect_w[i]) begin errors++; $display("FAIL drain_%0d got %h want %h", i, host_out_data, expect_w[i]); end
      host_out_ack = ~host_out_ack;
      tick(); tick(); tick();
    end
    vectors++; if (host_out_pending !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", host_out_pending); end
    vectors++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL drain_err got %b want 0", protocol_err); end
  endtask

  // Push coincident with a pop on a one-entry FIFO
  task automatic test_simul();
    core_out_valid = 1'b1;
    core_out_data  = 32'hAAAA0001;
    tick();
    core_out_valid = 1'b0;
    vectors++; if (host_out_data !== 32'hAAAA0001) begin errors++; $display("FAIL simul_first got %h want aaaa0001", host_out_data); end
    host_out_ack = ~host_out_ack;
    tick(); // E0
    tick(); // E1
    core_out_valid = 1'b1;
    core_out_data  = 32'hAAAA0002;
    tick(); // E2: push and pop together
    core_out_valid = 1'b0;
    vectors++; if (host_out_pending !== 1'b1) begin errors++; $display("FAIL simul_pending got %b want 1", host_out_pending); end
    vectors++; if (host_out_data !== 32'hAAAA0002) begin errors++; $display("FAIL simul_head got %h want aaaa0002", host_out_data); end
    vectors++; if (core_out_ready !== 1'b1) begin errors++; $display("FAIL simul_ready got %b want 1", core_out_ready); end
    host_out_ack = ~host_out_ack;
    tick(); tick(); tick();
    vectors++; if (host_out_pending !== 1'b0) begin errors++; $display("FAIL simul_drained got %b want 0", host_out_pending); end
  endtask

  // Input request served by a host toggle
  task automatic test_input();
    core_in_req  = 1'b1;
    host_in_data = 32'hDEADBEEF;
    #1;
    vectors++; if (core_stall !== 1'b1) begin errors++; $display("FAIL in_stall_idle got %b want 1", core_stall); end
    tick(); // to WAIT
    vectors++; if (host_in_req !== 1'b1) begin errors++; $display("FAIL in_host_req got %b want 1", host_in_req); end
    host_in_toggle = ~host_in_toggle;
    tick(); // E0
    tick(); // E1
    vectors++; if (host_in_req !== 1'b1) begin errors++; $display("FAIL in_host_req_e1 got %b want 1", host_in_req); end
    vectors++; if (core_in_valid !== 1'b0) begin errors++; $display("FAIL in_valid_e1 got %b want 0", core_in_valid); end
    vectors++; if (core_stall !== 1'b1) begin errors++; $display("FAIL in_stall_e1 got %b want 1", core_stall); end
    tick(); // E2: capture
    vectors++; if (core_in_valid !== 1'b1) begin errors++; $display("FAIL in_valid_e2 got %b want 1", core_in_valid); end
    vectors++; if (core_in_data !== 32'hDEADBEEF) begin errors++; $display("FAIL in_data_e2 got %h want deadbeef", core_in_data); end
    vectors++; if (host_in_req !== 1'b0) begin errors++; $display("FAIL in_host_req_e2 got %b want 0", host_in_req); end
    vectors++; if (core_stall !== 1'b0) begin errors++; $display("FAIL in_stall_deliver got %b want 0", core_stall); end
    core_in_req = 1'b0;
    tick(); // E3
    vectors++; if (core_in_valid !== 1'b0) begin errors++; $display("FAIL in_valid_e3 got %b want 0", core_in_valid); end
    vectors++; if (core_in_data !== 32'hDEADBEEF) begin errors++; $display("FAIL in_data_hold got %h want deadbeef", core_in_data); end
    vectors++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL in_err got %b want 0", protocol_err); end
  endtask

  // Ack while empty and in-toggle while idle both set the sticky error
  task automatic test_protocol_err();
    host_out_ack = ~host_out_ack;
    tick(); tick(); tick();
    vectors++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL err_ack_empty got %b want 1", protocol_err); end
    vectors++; if (host_out_pending !== 1'b0) begin errors++; $display("FAIL err_ack_pending got %b want 0", host_out_pending); end
    vectors++; if (core_out_ready !== 1'b1) begin errors++; $display("FAIL err_ack_ready got %b want 1", core_out_ready); end
    do_reset();
    vectors++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", protocol_err); end
    host_in_toggle = 1'b1;
    tick(); tick(); tick();
    vectors++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL err_tog_idle got %b want 1", protocol_err); end
    vectors++; if (host_in_req !== 1'b0) begin errors++; $display("FAIL err_tog_state got %b want 0", host_in_req); end
    vectors++; if (core_in_valid !== 1'b0) begin errors++; $display("FAIL err_tog_valid got %b want 0", core_in_valid); end
    tick(); tick(); tick(); tick();
    vectors++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", protocol_err); end
  endtask

  // Asynchronous reset while waiting with two words queued
  task automatic test_async_reset();
    do_reset();
    core_out_valid = 1'b1;
    core_out_data  = 32'hC0DE0001;
    tick();
    core_out_data  = 32'hC0DE0002;
    tick();
    core_out_valid = 1'b0;
    core_in_req    = 1'b1;
    tick(); // to WAIT
    vectors++; if (host_in_req !== 1'b1) begin errors++; $display("FAIL ar_wait got %b want 1", host_in_req); end
    vectors++; if (host_out_pending !== 1'b1) begin errors++; $display("FAIL ar_queued got %b want 1", host_out_pending); end
    #2;
    rst = 1'b1; // mid-cycle, no clock edge
    #1;
    vectors++; if (host_in_req !== 1'b0) begin errors++; $display("FAIL ar_host_req got %b want 0", host_in_req); end
    vectors++; if (host_out_pending !== 1'b0) begin errors++; $display("FAIL ar_pending got %b want 0", host_out_pending); end
    vectors++; if (core_out_ready !== 1'b1) begin errors++; $display("FAIL ar_ready got %b want 1", core_out_ready); end
    vectors++; if (core_stall !== 1'b1) begin errors++; $display("FAIL ar_stall_req got %b want 1", core_stall); end
    core_in_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    host_in_data = 32'h12345678;
    core_in_req  = 1'b1;
    tick(); // to WAIT
    host_in_toggle = ~host_in_toggle;
    tick(); tick(); tick();
    vectors++; if (core_in_valid !== 1'b1) begin errors++; $display("FAIL ar_new_valid got %b want 1", core_in_valid); end
    vectors++; if (core_in_data !== 32'h12345678) begin errors++; $display("FAIL ar_new_data got %h want 12345678", core_in_data); end
    core_in_req = 1'b0;
    tick();
    vectors++; if (core_in_valid !== 1'b0) begin errors++; $display("FAIL ar_new_pulse got %b want 0", core_in_valid); end
    vectors++; if (host_out_pending !== 1'b0) begin errors++; $display("FAIL ar_fifo_lost got %b want 0", host_out_pending); end
    vectors++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL ar_err got %b want 0", protocol_err); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_pop();
    test_simul();
    test_input();
    test_protocol_err();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
